// File: rtl/psum_pkg.sv
// Shared types, default geometry and the saturating adder used by the
// partial-sum accumulator.
package psum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned DEF_COL_LENGTH = 5;
  localparam int unsigned DEF_WORDLENGTH = 16;
  localparam int unsigned DEF_TILE_W     = 8;
  localparam int unsigned DEF_TILE_H     = 8;
  localparam int unsigned LANES          = 16;
  localparam int unsigned CH_W           = 6;

  // Full-precision signed add, clamped to the signed range of a w-bit word.
  // Operands are sign-extended to 32 bits by the caller; valid for w <= 31.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned w);
    logic signed [32:0] s;
    logic signed [32:0] max_v;
    logic signed [32:0] min_v;
    s     = {a[31], a} + {b[31], b};
    max_v = (33'sd1 <<< (w - 1)) - 33'sd1;
    min_v = -max_v - 33'sd1;
    if (s > max_v) begin
      sat_add = max_v[31:0];
    end else if (s < min_v) begin
      sat_add = min_v[31:0];
    end else begin
      sat_add = s[31:0];
    end
  endfunction

endpackage

// File: rtl/psum_bank.sv
// Partial-sum register file: one combinational read port, one write port and
// a per-entry clear port. Reset clears every entry.
module psum_bank #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 6
) (
  input  logic             clk,
  input  logic             irst_n,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign rd_data = mem_q[rd_addr];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
    if (clr_en) begin
      mem_d[clr_addr] = '0;
    end
  end

  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Output-stationary partial-sum accumulator: scatters 16-lane product bundles
// into a tile buffer with saturating accumulation and drains it row-major.
module psum_accumulator
  import psum_pkg::*;
#(
  parameter int unsigned col_length = DEF_COL_LENGTH,
  parameter int unsigned wordlength = DEF_WORDLENGTH,
  parameter int unsigned TILE_W     = DEF_TILE_W,
  parameter int unsigned TILE_H     = DEF_TILE_H
) (
  input  logic                         clk,
  input  logic                         irst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CH_W-1:0]              in_channel,
  input  logic [wordlength*LANES-1:0]  in_data,
  input  logic [col_length*LANES-1:0]  in_cols,
  input  logic [col_length*LANES-1:0]  in_rows,
  input  logic                         drain_req,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [wordlength-1:0]        out_data,
  output logic [col_length-1:0]        out_row,
  output logic [col_length-1:0]        out_col,
  output logic [CH_W-1:0]              out_channel,
  output logic                         out_last,
  output logic [15:0]                  drop_count
);

  localparam int unsigned DEPTH = TILE_W * TILE_H;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [col_length-1:0] ROW_LAST = col_length'(TILE_H - 1);
  localparam logic [col_length-1:0] COL_LAST = col_length'(TILE_W - 1);

  state_e                        state_q, state_d;
  logic                          pend_q, pend_d;
  logic                          has_data_q, has_data_d;
  logic [CH_W-1:0]               cur_ch_q, cur_ch_d;
  logic [3:0]                    lane_q, lane_d;
  logic [col_length-1:0]         drow_q, drow_d;
  logic [col_length-1:0]         dcol_q, dcol_d;
  logic [15:0]                   drop_q, drop_d;
  logic [wordlength*LANES-1:0]   data_q, data_d;
  logic [col_length*LANES-1:0]   cols_q, cols_d;
  logic [col_length*LANES-1:0]   rows_q, rows_d;

  logic signed [wordlength-1:0]  lane_data;
  logic [col_length-1:0]         lane_row;
  logic [col_length-1:0]         lane_col;
  logic                          lane_in_range;
  logic [AW-1:0]                 lane_addr;
  logic [AW-1:0]                 drain_addr;
  logic [AW-1:0]                 rd_addr;
  logic signed [wordlength-1:0]  rd_data;
  logic [wordlength-1:0]         wr_data;
  logic                          wr_en;
  logic                          clr_en;
  logic                          pend_now;
  logic                          ch_conflict;

  // A request arriving this cycle already blocks acceptance, so drain wins a tie.
  assign pend_now    = pend_q | drain_req;
  assign ch_conflict = has_data_q && (in_channel != cur_ch_q);
  assign in_ready    = (state_q == ST_IDLE) && !pend_now && !ch_conflict;

  always_comb begin
    lane_data     = data_q[32'(lane_q) * wordlength +: wordlength];
    lane_row      = rows_q[32'(lane_q) * col_length +: col_length];
    lane_col      = cols_q[32'(lane_q) * col_length +: col_length];
    lane_in_range = (32'(lane_row) < TILE_H) && (32'(lane_col) < TILE_W);
    lane_addr     = AW'(32'(lane_row) * TILE_W + 32'(lane_col));
    drain_addr    = AW'(32'(drow_q) * TILE_W + 32'(dcol_q));
    rd_addr       = (state_q == ST_DRAIN) ? drain_addr : lane_addr;
    wr_data       = wordlength'(sat_add(32'(rd_data), 32'(lane_data), wordlength));
  end

  assign out_valid   = (state_q == ST_DRAIN);
  assign out_data    = out_valid ? rd_data : '0;
  assign out_row     = out_valid ? drow_q : '0;
  assign out_col     = out_valid ? dcol_q : '0;
  assign out_channel = out_valid ? cur_ch_q : '0;
  assign out_last    = out_valid && (drow_q == ROW_LAST) && (dcol_q == COL_LAST);
  assign drop_count  = drop_q;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q | drain_req;
    has_data_d = has_data_q;
    cur_ch_d   = cur_ch_q;
    lane_d     = lane_q;
    drow_d     = drow_q;
    dcol_d     = dcol_q;
    drop_d     = drop_q;
    data_d     = data_q;
    cols_d     = cols_q;
    rows_d     = rows_q;
    wr_en      = 1'b0;
    clr_en     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pend_now || (in_valid && ch_conflict)) begin
          state_d = ST_DRAIN;
          pend_d  = 1'b0;
          drow_d  = '0;
          dcol_d  = '0;
        end else if (in_valid) begin
          state_d    = ST_ACCUM;
          data_d     = in_data;
          cols_d     = in_cols;
          rows_d     = in_rows;
          cur_ch_d   = in_channel;
          has_data_d = 1'b1;
          lane_d     = '0;
        end
      end
      ST_ACCUM: begin
        if (lane_in_range) begin
          wr_en = 1'b1;
        end else if (drop_q != 16'hFFFF) begin
          drop_d = drop_q + 16'd1;
        end
        lane_d = lane_q + 4'd1;
        if (lane_q == 4'd15) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          clr_en = 1'b1;
          if (dcol_q == COL_LAST) begin
            dcol_d = '0;
            if (drow_q == ROW_LAST) begin
              drow_d     = '0;
              state_d    = ST_IDLE;
              has_data_d = 1'b0;
            end else begin
              drow_d = drow_q + col_length'(1);
            end
          end else begin
            dcol_d = dcol_q + col_length'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      state_q    <= ST_IDLE;
      pend_q     <= 1'b0;
      has_data_q <= 1'b0;
      cur_ch_q   <= '0;
      lane_q     <= '0;
      drow_q     <= '0;
      dcol_q     <= '0;
      drop_q     <= '0;
      data_q     <= '0;
      cols_q     <= '0;
      rows_q     <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      has_data_q <= has_data_d;
      cur_ch_q   <= cur_ch_d;
      lane_q     <= lane_d;
      drow_q     <= drow_d;
      dcol_q     <= dcol_d;
      drop_q     <= drop_d;
      data_q     <= data_d;
      cols_q     <= cols_d;
      rows_q     <= rows_d;
    end
  end

  psum_bank #(
    .DEPTH (DEPTH),
    .WIDTH (wordlength),
    .AW    (AW)
  ) u_bank (
    .clk      (clk),
    .irst_n   (irst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (lane_addr),
    .wr_data  (wr_data),
    .clr_en   (clr_en),
    .clr_addr (drain_addr)
  );

endmodule
